// File: rtl/mem_arbiter.sv
// Arbiter that shares one main-memory block port between the I-cache (refill reads)
// and the D-cache (refill reads and write-backs), D-cache first with a starvation guard.
module mem_arbiter #(
   parameter int ADDR_W       = 28,
   parameter int DATA_W       = 128,
   parameter int STARVE_LIMIT = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IC_READ,
   input  logic [ADDR_W-1:0] IC_ADDR,
   output logic [DATA_W-1:0] IC_READDATA,
   output logic              IC_BUSYWAIT,
   input  logic              DC_READ,
   input  logic              DC_WRITE,
   input  logic [ADDR_W-1:0] DC_ADDR,
   input  logic [DATA_W-1:0] DC_WRITEDATA,
   output logic [DATA_W-1:0] DC_READDATA,
   output logic              DC_BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WRITEDATA,
   input  logic [DATA_W-1:0] MEM_READDATA,
   input  logic              MEM_BUSYWAIT,
   output logic [1:0]        GRANT
);

   // state  | meaning
   // IDLE   | no owner, arbitrate pending requests at the edge
   // BUSY_I | I-cache read issued, waiting for memory
   // BUSY_D | D-cache read/write issued, waiting for memory
   // RESP_I | one-cycle I-cache response, busywait released
   // RESP_D | one-cycle D-cache response, busywait released
   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

   localparam int STREAK_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   state_t              state_q, state_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
   logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;
   logic [STREAK_W-1:0] streak_q, streak_d;

   logic dc_req;
   logic dc_wins;

   assign dc_req  = DC_READ || DC_WRITE;
   // D-cache loses only when the I-cache has already waited through the full streak
   assign dc_wins = dc_req && !(IC_READ && (streak_q == STREAK_MAX));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ic_rdata_q  <= '0;
         dc_rdata_q  <= '0;
         streak_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ic_rdata_q  <= ic_rdata_d;
         dc_rdata_q  <= dc_rdata_d;
         streak_q    <= streak_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ic_rdata_d  = ic_rdata_q;
      dc_rdata_d  = dc_rdata_q;
      streak_d    = streak_q;
      case (state_q)
         IDLE: begin
            if (dc_wins) begin
               state_d    = BUSY_D;
               mem_addr_d = DC_ADDR;
               // a simultaneous read and write is served as the write-back
               if (DC_WRITE) begin
                  mem_write_d = 1'b1;
                  mem_wdata_d = DC_WRITEDATA;
               end else begin
                  mem_read_d = 1'b1;
               end
               if (!IC_READ)
                  streak_d = '0;
               else if (streak_q != STREAK_MAX)
                  streak_d = streak_q + STREAK_W'(1);
            end else if (IC_READ) begin
               state_d    = BUSY_I;
               mem_addr_d = IC_ADDR;
               mem_read_d = 1'b1;
               streak_d   = '0;
            end
         end
         BUSY_I: begin
            if (!MEM_BUSYWAIT) begin
               state_d    = RESP_I;
               mem_read_d = 1'b0;
               ic_rdata_d = MEM_READDATA;
            end
         end
         BUSY_D: begin
            if (!MEM_BUSYWAIT) begin
               state_d     = RESP_D;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (mem_read_q)
                  dc_rdata_d = MEM_READDATA;
            end
         end
         RESP_I:  state_d = IDLE;
         RESP_D:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      IC_BUSYWAIT = IC_READ && (state_q != RESP_I);
      DC_BUSYWAIT = dc_req && (state_q != RESP_D);
      case (state_q)
         BUSY_I, RESP_I: GRANT = 2'b01;
         BUSY_D, RESP_D: GRANT = 2'b10;
         default:        GRANT = 2'b00;
      endcase
   end

   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDR      = mem_addr_q;
   assign MEM_WRITEDATA = mem_wdata_q;
   assign IC_READDATA   = ic_rdata_q;
   assign DC_READDATA   = dc_rdata_q;

endmodule
